// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  // funct3 encoding of the M-extension operations
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  function automatic logic is_div(muldiv_op_t op);
    return op[2];
  endfunction

  function automatic logic is_rem(muldiv_op_t op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_a(muldiv_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(muldiv_op_t op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply and
// restoring divide on magnitudes, one bit per cycle, with a final sign fixup.
// Divide-by-zero and signed overflow complete in one cycle.
// Optional feature macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle
// '*' product at accept instead of the iterative loop.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int  XLEN  = XLEN_DEFAULT,
  localparam int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  muldiv_op_t      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  muldiv_state_t     state_q;
  muldiv_op_t        op_q;
  logic              neg_q;
  logic [CNT_W-1:0]  cnt_q;
  // mul: {product hi, multiplier/product lo}; div: {remainder, dividend/quotient}
  logic [2*XLEN-1:0] acc_q;
  // multiplicand magnitude or divisor magnitude
  logic [XLEN-1:0]   opd_q;
  logic [XLEN-1:0]   result_q;

  logic              sign_a, sign_b;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              fast_hit;
  logic [XLEN-1:0]   fast_res;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] step_d;
  logic [2*XLEN-1:0] acc_neg;
  logic [XLEN-1:0]   rem_neg;
  logic [XLEN-1:0]   fix_res;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fm_a, fm_b;
  logic        [2*XLEN-1:0] full_prod;

  // Sign- or zero-extend by op type; the low 2*XLEN bits of the modular product are exact.
  assign fm_a      = {is_signed_a(op) & op_a[XLEN-1], op_a};
  assign fm_b      = {is_signed_b(op) & op_b[XLEN-1], op_b};
  assign full_prod = (2*XLEN)'(fm_a) * (2*XLEN)'(fm_b);
`endif

  // Operand decode at accept: magnitudes and the single-cycle special cases
  always_comb begin
    sign_a   = is_signed_a(op) && op_a[XLEN-1];
    sign_b   = is_signed_b(op) && op_b[XLEN-1];
    abs_a    = sign_a ? (~op_a + 1'b1) : op_a;
    abs_b    = sign_b ? (~op_b + 1'b1) : op_b;
    fast_hit = 1'b0;
    fast_res = '0;
    if (is_div(op)) begin
      if (op_b == '0) begin
        fast_hit = 1'b1;
        fast_res = is_rem(op) ? op_a : '1;
      end else if (is_signed_a(op) && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1)) begin
        fast_hit = 1'b1;
        fast_res = is_rem(op) ? '0 : op_a;
      end
    end
`ifdef MULDIV_FAST_MUL_EN
    else begin
      fast_hit = 1'b1;
      fast_res = (op == OP_MUL) ? full_prod[XLEN-1:0] : full_prod[2*XLEN-1:XLEN];
    end
`endif
  end

  // One iteration of the shared shift datapath plus the final sign fixup
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opd_q};
    div_rem   = div_ge ? XLEN'(div_shift - {1'b0, opd_q}) : div_shift[XLEN-1:0];
    step_d    = is_div(op_q) ? {div_rem, acc_q[XLEN-2:0], div_ge}
                             : {mul_sum, acc_q[XLEN-1:1]};
    acc_neg   = ~acc_q + 1'b1;
    rem_neg   = ~acc_q[2*XLEN-1:XLEN] + 1'b1;
    case (op_q)
      OP_MUL:                      fix_res = neg_q ? acc_neg[XLEN-1:0] : acc_q[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = neg_q ? acc_neg[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fix_res = neg_q ? acc_neg[XLEN-1:0] : acc_q[XLEN-1:0];
      default:                     fix_res = neg_q ? rem_neg : acc_q[2*XLEN-1:XLEN];
    endcase
  end

  // Sequencer: accept, iterate XLEN times, fix sign, hold result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opd_q    <= '0;
      result_q <= '0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q  <= op;
            neg_q <= is_rem(op) ? sign_a : (sign_a ^ sign_b);
            cnt_q <= CNT_W'(XLEN - 1);
            if (fast_hit) begin
              result_q <= fast_res;
              state_q  <= DONE;
            end else begin
              acc_q   <= is_div(op) ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
              opd_q   <= is_div(op) ? abs_b : abs_a;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= step_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= SIGN;
        end
        SIGN: begin
          result_q <= fix_res;
          state_q  <= DONE;
        end
        default: begin
          if (out_ready) state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule
